game_state_ctrl: RTL and testbench

GAME_STATE_CTRL -- requirements
Module: game_state_ctrl

---
 rtl/game_state_ctrl.sv | 152 +++++++++++++++
 tb/tb_game_state_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/game_state_ctrl.sv
// Game flow controller: menu, play, hit (invulnerable), won and lost screens.
// Tracks lives and the frames-survived score. All outputs come straight from flops.
module game_state_ctrl #(
   parameter int WIN_TIME    = 200,
   parameter int LIVES       = 3,
   parameter int HOLD_FRAMES = 60
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        frame_tick,
   input  logic        start_btn,
   input  logic        collision,
   input  logic [10:0] game_time,
   output logic        menuScreen,
   output logic        playerWon,
   output logic        playerLost,
   output logic        invuln,
   output logic [1:0]  lives,
   output logic [15:0] score
);

   typedef enum logic [2:0] {
      S_MENU = 3'd0,
      S_PLAY = 3'd1,
      S_HIT  = 3'd2,
      S_WON  = 3'd3,
      S_LOST = 3'd4
   } state_t;

   localparam logic [10:0] WIN_T      = 11'(WIN_TIME);
   localparam logic [1:0]  LIVES_INIT = 2'(LIVES);
   localparam logic [7:0]  HOLD_LAST  = 8'(HOLD_FRAMES - 1);

   state_t      state_q, state_d;
   logic [1:0]  lives_q, lives_d;
   logic [15:0] score_q, score_d;
   logic [7:0]  hold_q, hold_d;
   logic        start_q, start_d;
   logic        menu_q, menu_d;
   logic        won_q, won_d;
   logic        lost_q, lost_d;
   logic        inv_q, inv_d;
   logic        start_rise;
   logic        win_hit;
   logic        hold_done;

   assign start_rise = start_btn & ~start_q;
   assign win_hit    = (game_time == WIN_T);
   assign hold_done  = frame_tick && (hold_q == HOLD_LAST);

   // Next-state, counters and registered Moore flags decoded from the next state
   always_comb begin
      state_d = state_q;
      lives_d = lives_q;
      score_d = score_q;
      hold_d  = hold_q;
      start_d = start_btn;

      // Frames survived while the player is on the field; saturates
      if (frame_tick && (state_q == S_PLAY || state_q == S_HIT) && score_q != 16'hFFFF)
         score_d = score_q + 16'd1;

      case (state_q)
         S_MENU: begin
            if (start_rise) begin
               state_d = S_PLAY;
               lives_d = LIVES_INIT;
               score_d = '0;
               hold_d  = '0;
            end
         end
         S_PLAY: begin
            // Collision wins over level completion in the same clk
            if (collision) begin
               hold_d = '0;
               if (lives_q <= 2'd1) begin
                  state_d = S_LOST;
                  lives_d = '0;
               end else begin
                  state_d = S_HIT;
                  lives_d = lives_q - 2'd1;
               end
            end else if (win_hit) begin
               state_d = S_WON;
               hold_d  = '0;
            end
         end
         S_HIT: begin
            // Collisions ignored; finishing the level while invulnerable still counts
            if (win_hit) begin
               state_d = S_WON;
               hold_d  = '0;
            end else if (hold_done) begin
               state_d = S_PLAY;
               hold_d  = '0;
            end else if (frame_tick) begin
               hold_d = hold_q + 8'd1;
            end
         end
         S_WON, S_LOST: begin
            if (start_rise || hold_done) begin
               state_d = S_MENU;
               hold_d  = '0;
            end else if (frame_tick) begin
               hold_d = hold_q + 8'd1;
            end
         end
         default: begin
            state_d = S_MENU;
            hold_d  = '0;
         end
      endcase

      menu_d = (state_d == S_MENU);
      won_d  = (state_d == S_WON);
      lost_d = (state_d == S_LOST);
      inv_d  = (state_d == S_HIT);
   end

   // State, counters and output flags; reset forces the menu screen immediately
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_MENU;
         lives_q <= LIVES_INIT;
         score_q <= '0;
         hold_q  <= '0;
         start_q <= 1'b0;
         menu_q  <= 1'b1;
         won_q   <= 1'b0;
         lost_q  <= 1'b0;
         inv_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         lives_q <= lives_d;
         score_q <= score_d;
         hold_q  <= hold_d;
         start_q <= start_d;
         menu_q  <= menu_d;
         won_q   <= won_d;
         lost_q  <= lost_d;
         inv_q   <= inv_d;
      end
   end

   assign menuScreen = menu_q;
   assign playerWon  = won_q;
   assign playerLost = lost_q;
   assign invuln     = inv_q;
   assign lives      = lives_q;
   assign score      = score_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed bench for game_state_ctrl: a vector table for the opening sequence,
// then hand-written sequences for hold timeouts, priorities, reset and saturation.
module tb_game_state_ctrl;

   logic        clk;
   logic        reset;
   logic        frame_tick;
   logic        start_btn;
   logic        collision;
   logic [10:0] game_time;
   logic        menuScreen, playerWon, playerLost, invuln;
   logic [1:0]  lives;
   logic [15:0] score;

   int checks = 0;
   int errors = 0;

   game_state_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .frame_tick (frame_tick),
      .start_btn  (start_btn),
      .collision  (collision),
      .game_time  (game_time),
      .menuScreen (menuScreen),
      .playerWon  (playerWon),
      .playerLost (playerLost),
      .invuln     (invuln),
      .lives      (lives),
      .score      (score)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        st;
      logic        co;
      logic        ft;
      logic [10:0] gt;
      logic        menu;
      logic        won;
      logic        lost;
      logic        inv;
      logic [1:0]  lv;
      logic [15:0] sc;
   } vec_t;

   vec_t tbl[12];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic chk_all(input string name, input logic m, input logic w, input logic l,
                          input logic i, input logic [1:0] lv, input logic [15:0] sc);
      chk({name, ".menuScreen"}, 32'(menuScreen), 32'(m));
      chk({name, ".playerWon"},  32'(playerWon),  32'(w));
      chk({name, ".playerLost"}, 32'(playerLost), 32'(l));
      chk({name, ".invuln"},     32'(invuln),     32'(i));
      chk({name, ".lives"},      32'(lives),      32'(lv));
      chk({name, ".score"},      32'(score),      32'(sc));
   endtask

   // One clock with the given inputs; outputs are sampled 1 time unit after the edge
   task automatic step(input logic s, input logic c, input logic f, input logic [10:0] g);
      start_btn  = s;
      collision  = c;
      frame_tick = f;
      game_time  = g;
      @(posedge clk);
      #1;
   endtask

   task automatic frames(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b1, 11'd0);
   endtask

   initial begin
      //          st co ft gt     menu won lost inv lives score
      tbl[0]  = '{0, 0, 0, 11'd0,   1, 0, 0, 0, 2'd3, 16'd0};
      tbl[1]  = '{1, 0, 0, 11'd0,   0, 0, 0, 0, 2'd3, 16'd0};
      tbl[2]  = '{1, 0, 0, 11'd0,   0, 0, 0, 0, 2'd3, 16'd0};
      tbl[3]  = '{1, 0, 0, 11'd0,   0, 0, 0, 0, 2'd3, 16'd0};
      tbl[4]  = '{1, 0, 0, 11'd0,   0, 0, 0, 0, 2'd3, 16'd0};
      tbl[5]  = '{1, 0, 0, 11'd0,   0, 0, 0, 0, 2'd3, 16'd0};
      tbl[6]  = '{0, 0, 0, 11'd0,   0, 0, 0, 0, 2'd3, 16'd0};
      tbl[7]  = '{0, 0, 1, 11'd0,   0, 0, 0, 0, 2'd3, 16'd1};
      tbl[8]  = '{0, 0, 1, 11'd0,   0, 0, 0, 0, 2'd3, 16'd2};
      tbl[9]  = '{0, 1, 0, 11'd0,   0, 0, 0, 1, 2'd2, 16'd2};
      tbl[10] = '{0, 1, 1, 11'd0,   0, 0, 0, 1, 2'd2, 16'd3};
      tbl[11] = '{0, 0, 1, 11'd199, 0, 0, 0, 1, 2'd2, 16'd4};

      reset      = 1'b1;
      start_btn  = 1'b0;
      collision  = 1'b0;
      frame_tick = 1'b0;
      game_time  = 11'd0;
      #2;
      chk_all("reset", 1, 0, 0, 0, 2'd3, 16'd0);
      #10 reset = 1'b0;

      // Start held 5 clks gives one entry into PLAY; hit and a collision during HIT
      for (int v = 0; v < 12; v++) begin
         step(tbl[v].st, tbl[v].co, tbl[v].ft, tbl[v].gt);
         chk_all($sformatf("vec%0d", v), tbl[v].menu, tbl[v].won, tbl[v].lost,
                 tbl[v].inv, tbl[v].lv, tbl[v].sc);
      end

      // HIT lasts 60 frame ticks in total (two already given by the table)
      frames(57);
      chk_all("hit1_last", 0, 0, 0, 1, 2'd2, 16'd61);
      frames(1);
      chk_all("hit1_exit", 0, 0, 0, 0, 2'd2, 16'd62);

      // Second collision, full hold, third collision -> LOST, hold -> MENU
      step(0, 1, 0, 11'd0);
      chk_all("hit2", 0, 0, 0, 1, 2'd1, 16'd62);
      frames(59);
      chk_all("hit2_last", 0, 0, 0, 1, 2'd1, 16'd121);
      frames(1);
      chk_all("hit2_exit", 0, 0, 0, 0, 2'd1, 16'd122);
      step(0, 1, 0, 11'd0);
      chk_all("lost", 0, 0, 1, 0, 2'd0, 16'd122);
      frames(59);
      chk_all("lost_last", 0, 0, 1, 0, 2'd0, 16'd122);
      frames(1);
      chk_all("lost_exit", 1, 0, 0, 0, 2'd0, 16'd122);

      // Collision and win in the same clk: collision wins; then win while in HIT
      step(1, 0, 0, 11'd0);
      chk_all("restart1", 0, 0, 0, 0, 2'd3, 16'd0);
      step(0, 1, 0, 11'd200);
      chk_all("coll_prio", 0, 0, 0, 1, 2'd2, 16'd0);
      step(0, 0, 0, 11'd200);
      chk_all("hit_win", 0, 1, 0, 0, 2'd2, 16'd0);
      step(1, 0, 0, 11'd0);
      chk_all("won_start", 1, 0, 0, 0, 2'd2, 16'd0);

      // Plain win: score frozen, start at frame 10 exits at once
      step(0, 0, 0, 11'd0);
      step(1, 0, 0, 11'd0);
      chk_all("restart2", 0, 0, 0, 0, 2'd3, 16'd0);
      frames(10);
      chk_all("play10", 0, 0, 0, 0, 2'd3, 16'd10);
      step(0, 0, 0, 11'd200);
      chk_all("won", 0, 1, 0, 0, 2'd3, 16'd10);
      frames(9);
      chk_all("won_hold", 0, 1, 0, 0, 2'd3, 16'd10);
      step(1, 0, 1, 11'd0);
      chk_all("won_exit", 1, 0, 0, 0, 2'd3, 16'd10);

      // Asynchronous reset during HIT with score 37
      step(0, 0, 0, 11'd0);
      step(1, 0, 0, 11'd0);
      frames(36);
      step(0, 1, 1, 11'd0);
      chk_all("hit37", 0, 0, 0, 1, 2'd2, 16'd37);
      reset = 1'b1;
      #1;
      chk_all("async_rst", 1, 0, 0, 0, 2'd3, 16'd0);
      #3 reset = 1'b0;

      // First rise after reset starts a game; then score saturation
      step(1, 0, 0, 11'd0);
      chk_all("post_rst", 0, 0, 0, 0, 2'd3, 16'd0);
      frames(65535);
      chk_all("sat_reach", 0, 0, 0, 0, 2'd3, 16'hFFFF);
      frames(1);
      chk_all("sat_hold", 0, 0, 0, 0, 2'd3, 16'hFFFF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
